mem_sort_checker: RTL and testbench

MEM_SORT_CHECKER -- requirements
Module: mem_sort_checker

---
 rtl/mem_check_pkg.sv | 13 +
 rtl/mem_sort_checker.sv | 147 ++++++++++++++
 tb/tb_mem_sort_checker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_check_pkg.sv
// Shared types and constants for the sorted-memory checker.
package mem_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/mem_sort_checker.sv
// Scans CHECK_LEN words of a 1-cycle-latency memory and counts order violations.
// Optional MEM_SORT_CHECKER_SUM_EN also checks a wrapping word sum against EXP_SUM.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SCAN  | issuing addresses and consuming read data
// DONE  | results valid and held; start restarts a scan
module mem_sort_checker
    import mem_check_pkg::*;
#(
    parameter int          ADDR_LEN  = 11,
    parameter int          CHECK_LEN = 256,
    parameter logic [31:0] EXP_SUM   = 32'h0000_7F80
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic                 mem_wr_req,
    output logic [31:0]          mem_wr_data,
    input  logic [31:0]          mem_rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_LEN-1:0]  first_err_addr
`ifdef MEM_SORT_CHECKER_SUM_EN
    ,
    output logic [31:0]          sum_out
`endif
);

    localparam int IDX_W = ADDR_LEN + 1;
    localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(CHECK_LEN - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(CHECK_LEN);

    state_t                 state_q, state_d;
    logic [ADDR_LEN-1:0]    mem_addr_q, mem_addr_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [31:0]            prev_q, prev_d;
    logic [31:0]            sum_q, sum_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_LEN-1:0]    first_err_addr_q, first_err_addr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   sum_ok;

    always_comb begin
        state_d          = state_q;
        mem_addr_d       = mem_addr_q;
        idx_d            = idx_q;
        prev_d           = prev_q;
        sum_d            = sum_q;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        sum_ok           = 1'b1;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d          = SCAN;
                    mem_addr_d       = '0;
                    idx_d            = '0;
                    prev_d           = '0;
                    sum_d            = '0;
                    err_cnt_d        = '0;
                    first_err_addr_d = '0;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                end
            end
            SCAN: begin
                if (mem_addr_q != LAST_ADDR) begin
                    mem_addr_d = mem_addr_q + 1'b1;
                end
                idx_d = idx_q + 1'b1;
                // idx_q counts edges since start; read data for word idx_q-1 is valid now
                if (idx_q != '0) begin
                    prev_d = mem_rd_data;
                    sum_d  = sum_q + mem_rd_data;
                    if ((idx_q >= IDX_W'(2)) && (mem_rd_data < prev_q)) begin
                        if (err_cnt_q == '0) begin
                            first_err_addr_d = ADDR_LEN'(idx_q - IDX_W'(1));
                        end
                        if (err_cnt_q != ERR_CNT_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
`ifdef MEM_SORT_CHECKER_SUM_EN
                        sum_ok = (sum_d == EXP_SUM);
`endif
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == '0) && sum_ok;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            mem_addr_q       <= '0;
            idx_q            <= '0;
            prev_q           <= '0;
            sum_q            <= '0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            mem_addr_q       <= mem_addr_d;
            idx_q            <= idx_d;
            prev_q           <= prev_d;
            sum_q            <= sum_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_wr_req     = 1'b0;
    assign mem_wr_data    = '0;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_addr_q;
`ifdef MEM_SORT_CHECKER_SUM_EN
    assign sum_out        = sum_q;
`endif

endmodule

// File: tb/tb_mem_sort_checker.sv
// Bench for mem_sort_checker: behavioural scan model checked every cycle plus directed literals.
module tb_mem_sort_checker;

`ifdef MEM_SORT_CHECKER_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif
    localparam int AW = 11;
    localparam int CL = 256;
    localparam logic [31:0] EXP = 32'h0000_7F80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start1 = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Main DUT (CHECK_LEN=256) and its synchronous memory
    logic [AW-1:0] mem_addr, first_err_addr;
    logic          mem_wr_req, busy, done, pass;
    logic [31:0]   mem_wr_data, mem_rd_data;
    logic [15:0]   err_cnt;
    logic [31:0]   sum_out;
    logic [31:0]   mem [0:(1<<AW)-1];

    always @(posedge clk) mem_rd_data <= mem[mem_addr];

    mem_sort_checker #(.ADDR_LEN(AW), .CHECK_LEN(CL), .EXP_SUM(EXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_addr(first_err_addr)
`ifdef MEM_SORT_CHECKER_SUM_EN
        , .sum_out(sum_out)
`endif
    );
`ifndef MEM_SORT_CHECKER_SUM_EN
    assign sum_out = '0;
`endif

    // Second DUT with CHECK_LEN=1
    logic [AW-1:0] mem_addr1, first_err_addr1;
    logic          mem_wr_req1, busy1, done1, pass1;
    logic [31:0]   mem_wr_data1, mem_rd_data1;
    logic [15:0]   err_cnt1;
    logic [31:0]   mem1 [0:(1<<AW)-1];

    always @(posedge clk) mem_rd_data1 <= mem1[mem_addr1];

    mem_sort_checker #(.ADDR_LEN(AW), .CHECK_LEN(1), .EXP_SUM(32'h0000_0042)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .mem_addr(mem_addr1), .mem_wr_req(mem_wr_req1), .mem_wr_data(mem_wr_data1),
        .mem_rd_data(mem_rd_data1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err_cnt1), .first_err_addr(first_err_addr1)
`ifdef MEM_SORT_CHECKER_SUM_EN
        , .sum_out()
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: results over the first c words of the snapshot taken at start
    typedef struct packed {
        logic [15:0]   err;
        logic [AW-1:0] first;
        logic [31:0]   sum;
    } res_t;

    logic [31:0] snap [0:CL-1];
    logic        m_active = 1'b0;
    int          m_k = 0;

    function automatic res_t model(input int c);
        res_t r;
        r = '0;
        for (int j = 0; j < c; j++) begin
            r.sum = r.sum + snap[j];
            if (j >= 1 && snap[j] < snap[j-1]) begin
                if (r.err == 0) r.first = AW'(j);
                if (r.err != 16'hFFFF) r.err = r.err + 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (start && (!m_active || m_k > CL)) begin
            m_active <= 1'b1;
            m_k      <= 0;
            for (int i = 0; i < CL; i++) snap[i] <= mem[i];
        end else if (m_active && m_k < 100000) begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        res_t r;
        int   c;
        logic exp_done;
        if (!m_active) begin
            chk("idle_busy", 32'(busy), 0);
            chk("idle_done", 32'(done), 0);
            chk("idle_pass", 32'(pass), 0);
            chk("idle_err_cnt", 32'(err_cnt), 0);
            chk("idle_first", 32'(first_err_addr), 0);
            chk("idle_addr", 32'(mem_addr), 0);
            if (SUM_EN) chk("idle_sum", sum_out, 0);
        end else begin
            c = (m_k == 0) ? 0 : m_k - 1;
            if (c > CL) c = CL;
            r = model(c);
            exp_done = (m_k > CL);
            chk("busy", 32'(busy), 32'(!exp_done));
            chk("done", 32'(done), 32'(exp_done));
            chk("mem_addr", 32'(mem_addr), (m_k < CL - 1) ? 32'(m_k) : 32'(CL - 1));
            chk("err_cnt", 32'(err_cnt), 32'(r.err));
            chk("first_err_addr", 32'(first_err_addr), 32'(r.first));
            chk("pass", 32'(pass),
                32'(exp_done && r.err == 0 && (!SUM_EN || r.sum == EXP)));
            if (SUM_EN) chk("sum_out", sum_out, r.sum);
        end
        chk("wr_req", 32'(mem_wr_req), 0);
        chk("wr_data", mem_wr_data, 0);
    end

    // Pulse start, optionally re-pulse mid-scan, measure done latency and check literals
    task automatic run_scan(input int mid, input logic [15:0] e_err, input logic [AW-1:0] e_first,
                            input logic e_pass, input logic [31:0] e_sum, input string tag);
        int n;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (mid != 0) && (n == mid);
            if (done) break;
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(n), 257);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e_err));
        chk({tag, "_first"}, 32'(first_err_addr), 32'(e_first));
        chk({tag, "_pass"}, 32'(pass), 32'(e_pass));
        if (SUM_EN) chk({tag, "_sum"}, sum_out, e_sum);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]  = (i < CL) ? 32'(i) : 32'h0;
            mem1[i] = 32'h0;
        end
        mem1[0] = 32'h42;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);

        run_scan(0, 16'd0, 11'd0, 1'b1, 32'h7F80, "sorted");

        mem[10] = 32'd11; mem[11] = 32'd10;
        run_scan(0, 16'd1, 11'd11, 1'b0, 32'h7F80, "swapped");

        for (int i = 0; i < CL; i++) mem[i] = 32'(255 - i);
        run_scan(0, 16'd255, 11'd1, 1'b0, 32'h7F80, "descending");

        for (int i = 0; i < CL; i++) mem[i] = 32'h5;
        run_scan(0, 16'd0, 11'd0, !SUM_EN, 32'h500, "all_equal");

        for (int i = 0; i < CL; i++) mem[i] = 32'(i);
        run_scan(50, 16'd0, 11'd0, 1'b1, 32'h7F80, "mid_start");

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_addr", 32'(mem_addr), 0);
        chk("abort_err", 32'(err_cnt), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_scan(0, 16'd0, 11'd0, 1'b1, 32'h7F80, "after_reset");

        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("len1_busy_e0", 32'(busy1), 1);
        @(negedge clk);
        chk("len1_done_e1", 32'(done1), 0);
        @(negedge clk);
        chk("len1_done_e2", 32'(done1), 1);
        chk("len1_busy_e2", 32'(busy1), 0);
        chk("len1_pass", 32'(pass1), 1);
        chk("len1_err", 32'(err_cnt1), 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
